// File: rtl/blake2b_msg_packer.sv
// blake2b_msg_packer
// Collects a message of 64-bit little-endian words into a single zero-padded
// 1024-bit block, hands it to the Blake2b hasher with a one-cycle valid, and
// stalls further input until the hasher reports completion. Messages longer
// than one block are flagged and discarded up to their last word.
module blake2b_msg_packer #(
    parameter int WORD_W = 64,
    parameter int WORDS  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WORD_W-1:0]         in_data_i,
    input  logic                      in_last_i,
    input  logic [2:0]                in_nbytes_i,
    output logic                      valid_o,
    output logic [WORD_W*WORDS-1:0]   data_o,
    output logic [7:0]                len_o,
    input  logic                      hash_v_i,
    output logic                      err_o
);

    localparam int BLK_W = WORD_W * WORDS;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Byte-enable mask for the final word: nbytes of 0 encodes a full word.
    function automatic logic [WORD_W-1:0] last_word_mask(input logic [2:0] nbytes);
        logic [WORD_W-1:0] m;
        m = {WORD_W{1'b0}};
        for (int b = 0; b < WORD_W / 8; b++) begin
            if ((nbytes == 3'd0) || (b < int'(nbytes))) begin
                m[b*8 +: 8] = 8'hFF;
            end else begin
                m[b*8 +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    // Number of valid bytes in the final word (1..8).
    function automatic logic [3:0] last_word_bytes(input logic [2:0] nbytes);
        logic [3:0] n;
        if (nbytes == 3'd0) begin
            n = 4'd8;
        end else begin
            n = {1'b0, nbytes};
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [BLK_W-1:0]   data_q, data_d;
    logic [7:0]         len_q, len_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               accept_s;
    logic [WORD_W-1:0]  word_s;
    logic [9:0]         slot_base_s;

    assign in_ready_o = ready_q;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign len_o      = len_q;
    assign err_o      = err_q;

    // Handshake and the word as it will be stored (tail bytes zeroed on last).
    always_comb begin
        accept_s    = in_valid_i & ready_q;
        slot_base_s = {wcnt_q, 6'd0};
        if (in_last_i) begin
            word_s = in_data_i & last_word_mask(in_nbytes_i);
        end else begin
            word_s = in_data_i;
        end
    end

    // Next-state logic for the packing FSM and its datapath.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    data_d[slot_base_s +: WORD_W] = word_s;
                    wcnt_d = wcnt_q + 4'd1;
                    if (in_last_i) begin
                        len_d   = {1'b0, wcnt_q, 3'b000} + {4'd0, last_word_bytes(in_nbytes_i)};
                        state_d = ST_SEND;
                    end else if (wcnt_q == 4'd15) begin
                        // A 17th word would follow: the message cannot fit.
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (hash_v_i) begin
                    state_d = ST_FILL;
                    wcnt_d  = 4'd0;
                    data_d  = {BLK_W{1'b0}};
                    len_d   = 8'd0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (accept_s && in_last_i) begin
                    state_d = ST_FILL;
                    wcnt_d  = 4'd0;
                    data_d  = {BLK_W{1'b0}};
                    len_d   = 8'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_FILL;
                wcnt_d  = 4'd0;
                data_d  = {BLK_W{1'b0}};
                len_d   = 8'd0;
            end
        endcase
        valid_d = (state_d == ST_SEND);
        ready_d = (state_d == ST_FILL) || (state_d == ST_DROP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            wcnt_q  <= 4'd0;
            data_q  <= {BLK_W{1'b0}};
            len_q   <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

endmodule
